// File: rtl/mdio_mgmt_ctrl.sv
// mdio_mgmt_ctrl: sequences the mdio_driver for a single PHY.
// After reset it waits, writes the initial BMCR value and polls BMCR until
// the self-clearing reset bit drops. It then polls BMSR for link status on
// a fixed interval and shares the driver with one host register port.
module mdio_mgmt_ctrl #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] INIT_BMCR     = 16'h9140,
    parameter int unsigned RST_WAIT      = 1000,
    parameter int unsigned POLL_INTERVAL = 1000000,
    parameter int unsigned TIMEOUT       = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        mdio_start,
    output logic        mdio_is_rd,
    output logic [4:0]  mdio_phy_addr,
    output logic [4:0]  mdio_reg_addr,
    output logic [15:0] mdio_wr_data,
    input  logic [15:0] mdio_rd_data,
    input  logic        mdio_o_vld,

    input  logic        host_req,
    input  logic        host_is_rd,
    input  logic [4:0]  host_reg_addr,
    input  logic [15:0] host_wr_data,
    output logic        host_ack,
    output logic [15:0] host_rd_data,

    output logic        init_done,
    output logic        link_up,
    output logic        link_chg,
    output logic        mdio_err
);

    localparam int GW = (RST_WAIT > 1)      ? $clog2(RST_WAIT)      : 1;
    localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = (TIMEOUT > 1)       ? $clog2(TIMEOUT)       : 1;

    localparam logic [GW-1:0] GAP_LAST  = GW'(RST_WAIT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [2:0] ST_RST_WAIT = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_IDLE     = 3'd4;

    localparam logic [1:0] OWN_INIT = 2'd0;
    localparam logic [1:0] OWN_POLL = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;

    logic [2:0]    state;
    logic [1:0]    owner;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [PW-1:0] poll_cnt;
    logic          poll_pending;
    logic          poll_tick;
    logic          last_host;
    logic          op_is_rd;
    logic [4:0]    op_reg;
    logic [15:0]   op_wdata;
    logic          op_done;
    logic [15:0]   rsp_data;
    logic          host_ok;
    logic          take_poll;
    logic          take_host;

    // The command fields are held in op_* from the issue decision until
    // completion, so the driver sees them stable for the whole transaction.
    assign mdio_start    = (state == ST_ISSUE);
    assign mdio_is_rd    = op_is_rd;
    assign mdio_phy_addr = PHY_ADDR;
    assign mdio_reg_addr = op_reg;
    assign mdio_wr_data  = op_wdata;

    // Completion is either the driver pulse or an abandoned transaction;
    // an abandoned read reports all-ones like an absent PHY would.
    assign op_done  = (state == ST_WAIT) && (mdio_o_vld || (to_cnt == TO_LAST));
    assign rsp_data = mdio_o_vld ? mdio_rd_data : 16'hFFFF;

    // Arbitration: the host is blocked during its own ack cycle so a level
    // request that has not yet been dropped is not accepted twice. When both
    // sources compete the poll wins only right after a host op.
    assign host_ok   = host_req && init_done && !host_ack;
    assign take_poll = (state == ST_IDLE) && poll_pending && (!host_ok || last_host);
    assign take_host = (state == ST_IDLE) && host_ok && !take_poll;

    assign poll_tick = init_done && (poll_cnt == POLL_LAST);

    // Free-running poll interval timer; a tick while a poll is already
    // pending simply leaves it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            if (!init_done || poll_tick) begin
                poll_cnt <= '0;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
            if (poll_tick) begin
                poll_pending <= 1'b1;
            end else if (take_poll) begin
                poll_pending <= 1'b0;
            end
        end
    end

    // Main sequencer: init, issue/wait, completion dispatch and arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RST_WAIT;
            owner        <= OWN_INIT;
            gap_cnt      <= '0;
            to_cnt       <= '0;
            last_host    <= 1'b0;
            op_is_rd     <= 1'b0;
            op_reg       <= 5'd0;
            op_wdata     <= 16'h0000;
            init_done    <= 1'b0;
            link_up      <= 1'b0;
            link_chg     <= 1'b0;
            mdio_err     <= 1'b0;
            host_ack     <= 1'b0;
            host_rd_data <= 16'h0000;
        end else begin
            link_chg <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                ST_RST_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        owner    <= OWN_INIT;
                        op_is_rd <= 1'b0;
                        op_reg   <= REG_BMCR;
                        op_wdata <= INIT_BMCR;
                        state    <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        owner    <= OWN_INIT;
                        op_is_rd <= 1'b1;
                        op_reg   <= REG_BMCR;
                        op_wdata <= 16'h0000;
                        state    <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= TW'(1);
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (op_done) begin
                        if (!mdio_o_vld) begin
                            mdio_err <= 1'b1;
                        end
                        case (owner)
                            OWN_INIT: begin
                                if (!op_is_rd || rsp_data[15]) begin
                                    state <= ST_GAP;
                                end else begin
                                    init_done <= 1'b1;
                                    state     <= ST_IDLE;
                                end
                            end
                            OWN_POLL: begin
                                if (mdio_o_vld) begin
                                    link_up  <= rsp_data[2];
                                    link_chg <= (rsp_data[2] != link_up);
                                end
                                last_host <= 1'b0;
                                state     <= ST_IDLE;
                            end
                            default: begin
                                host_ack     <= 1'b1;
                                host_rd_data <= op_is_rd ? rsp_data : 16'h0000;
                                last_host    <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (take_poll) begin
                        owner    <= OWN_POLL;
                        op_is_rd <= 1'b1;
                        op_reg   <= REG_BMSR;
                        op_wdata <= 16'h0000;
                        state    <= ST_ISSUE;
                    end else if (take_host) begin
                        owner    <= OWN_HOST;
                        op_is_rd <= host_is_rd;
                        op_reg   <= host_reg_addr;
                        op_wdata <= host_is_rd ? 16'h0000 : host_wr_data;
                        state    <= ST_ISSUE;
                    end
                end
                default: begin
                    state <= ST_RST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// tb_mdio_mgmt_ctrl: directed bench for mdio_mgmt_ctrl with a behavioural
// PHY/driver model answering commands after a fixed latency.
module tb_mdio_mgmt_ctrl;

    localparam int RST_WAIT      = 10;
    localparam int POLL_INTERVAL = 300;
    localparam int TIMEOUT       = 100;
    localparam int PHY_LAT       = 20;

    typedef struct packed {
        logic        is_rd;
        logic [4:0]  reg_addr;
        logic [15:0] wr_data;
        logic [15:0] exp_rd;
    } host_vec_t;

    logic        clk;
    logic        rst_n;
    logic        mdio_start;
    logic        mdio_is_rd;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_reg_addr;
    logic [15:0] mdio_wr_data;
    logic [15:0] mdio_rd_data;
    logic        mdio_o_vld;
    logic        host_req;
    logic        host_is_rd;
    logic [4:0]  host_reg_addr;
    logic [15:0] host_wr_data;
    logic        host_ack;
    logic [15:0] host_rd_data;
    logic        init_done;
    logic        link_up;
    logic        link_chg;
    logic        mdio_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // PHY model state and transaction log
    logic [15:0] bmsr = 16'h796D;
    logic [15:0] mem [32];
    bit          suppress = 1'b0;
    int          bmcr_reads = 0;
    int          init_writes = 0;
    int          init_reads = 0;
    int          poll_starts = 0;
    int          host_starts = 0;
    int          init_start_cyc = 0;
    logic [15:0] init_wdata = 16'h0;
    int          last_init_vld_cyc = 0;
    int          last_poll_vld_cyc = 0;
    int          last_host_vld_cyc = 0;
    int          last_host_start_cyc = 0;
    logic        last_host_is_rd = 1'b0;
    logic [4:0]  last_host_reg = 5'd0;
    logic [15:0] last_host_wd = 16'h0;
    int          poll_q[$];
    bit          order_q[$];

    // Monitor state
    bit outstanding = 1'b0;
    int ost_age = 0;
    int overlap_errs = 0;
    int chg_count = 0;
    int last_chg_cyc = 0;
    int ack_before_init = 0;
    int init_rise_cyc = 0;
    bit prev_init = 1'b0;

    host_vec_t vecs [6];

    mdio_mgmt_ctrl #(
        .PHY_ADDR      (5'd1),
        .INIT_BMCR     (16'h9140),
        .RST_WAIT      (RST_WAIT),
        .POLL_INTERVAL (POLL_INTERVAL),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mdio_start    (mdio_start),
        .mdio_is_rd    (mdio_is_rd),
        .mdio_phy_addr (mdio_phy_addr),
        .mdio_reg_addr (mdio_reg_addr),
        .mdio_wr_data  (mdio_wr_data),
        .mdio_rd_data  (mdio_rd_data),
        .mdio_o_vld    (mdio_o_vld),
        .host_req      (host_req),
        .host_is_rd    (host_is_rd),
        .host_reg_addr (host_reg_addr),
        .host_wr_data  (host_wr_data),
        .host_ack      (host_ack),
        .host_rd_data  (host_rd_data),
        .init_done     (init_done),
        .link_up       (link_up),
        .link_chg      (link_chg),
        .mdio_err      (mdio_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter, advanced on every rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // PHY/driver model: sees mdio_start on the falling edge, answers after
    // PHY_LAT cycles with a one-cycle mdio_o_vld, abandons on reset.
    initial begin
        logic        t_rd;
        logic [4:0]  t_reg;
        logic [15:0] t_wd;
        logic [15:0] data;
        int          cls;
        bit          aborted;
        mdio_o_vld   = 1'b0;
        mdio_rd_data = 16'h0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        mem[2] = 16'h0141;
        mem[3] = 16'h0C54;
        forever begin
            @(negedge clk);
            if (rst_n && mdio_start) begin
                t_rd  = mdio_is_rd;
                t_reg = mdio_reg_addr;
                t_wd  = mdio_wr_data;
                if (t_reg == 5'd0) begin
                    cls = 0;
                    if (!t_rd) begin
                        init_writes++;
                        init_start_cyc = cyc;
                        init_wdata = t_wd;
                        bmcr_reads = 0;
                    end else begin
                        init_reads++;
                    end
                end else if (t_reg == 5'd1 && t_rd) begin
                    cls = 1;
                    poll_starts++;
                    poll_q.push_back(cyc);
                    order_q.push_back(1'b1);
                end else begin
                    cls = 2;
                    host_starts++;
                    last_host_start_cyc = cyc;
                    last_host_is_rd = t_rd;
                    last_host_reg = t_reg;
                    last_host_wd = t_wd;
                    order_q.push_back(1'b0);
                end
                aborted = 1'b0;
                for (int i = 0; i < PHY_LAT; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && !(suppress && cls == 2)) begin
                    data = 16'h0;
                    if (t_rd) begin
                        if (t_reg == 5'd0) begin
                            bmcr_reads++;
                            data = (bmcr_reads == 1) ? 16'h9140 : 16'h1140;
                        end else if (t_reg == 5'd1) begin
                            data = bmsr;
                        end else begin
                            data = mem[t_reg];
                        end
                    end else if (t_reg != 5'd0) begin
                        mem[t_reg] = t_wd;
                    end
                    if (cls == 0) last_init_vld_cyc = cyc;
                    else if (cls == 1) last_poll_vld_cyc = cyc;
                    else last_host_vld_cyc = cyc;
                    outstanding = 1'b0;
                    mdio_rd_data = data;
                    mdio_o_vld = 1'b1;
                    @(negedge clk);
                    mdio_o_vld = 1'b0;
                end
            end
        end
    end

    // Output monitor: overlap of commands, link_chg/ack pulses, init rise
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
            end else if (mdio_start) begin
                if (outstanding) overlap_errs++;
                outstanding = 1'b1;
                ost_age = 0;
            end else if (outstanding) begin
                ost_age++;
                if (ost_age >= TIMEOUT - 1) outstanding = 1'b0;
            end
            if (link_chg) begin
                chg_count++;
                last_chg_cyc = cyc;
            end
            if (host_ack && !init_done) ack_before_init++;
            if (init_done && !prev_init) init_rise_cyc = cyc;
            prev_init = init_done;
        end
    end

    // Global watchdog so the bench always ends
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic waitAck(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitInit(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitChg(input int target, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (chg_count >= target) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // One host transaction from the vector table, checked end to end
    task automatic applyStimulus(input host_vec_t v, input int idx);
        int hs0;
        bit got;
        hs0 = host_starts;
        host_is_rd    = v.is_rd;
        host_reg_addr = v.reg_addr;
        host_wr_data  = v.wr_data;
        host_req      = 1'b1;
        waitAck(500, got);
        host_req = 1'b0;
        checkOutput($sformatf("vec%0d_ack_seen", idx), 32'(got), 32'd1);
        if (got) begin
            checkOutput($sformatf("vec%0d_rd_data", idx), 32'(host_rd_data), 32'(v.exp_rd));
            checkOutput($sformatf("vec%0d_ack_latency", idx), 32'(cyc - last_host_vld_cyc), 32'd1);
            checkOutput($sformatf("vec%0d_start_count", idx), 32'(host_starts - hs0), 32'd1);
            checkOutput($sformatf("vec%0d_cmd_fields", idx), 32'({last_host_is_rd, last_host_reg}), 32'({v.is_rd, v.reg_addr}));
            if (!v.is_rd) begin
                checkOutput($sformatf("vec%0d_cmd_wdata", idx), 32'(last_host_wd), 32'(v.wr_data));
            end
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ack_one_cycle", idx), 32'(host_ack), 32'd0);
        end
    endtask

    initial begin
        bit got;
        int rel_cyc;
        int w0;
        int r0;
        int p0;
        int ord0;
        int npoll;
        int viol;
        int bad_data;

        vecs[0] = '{is_rd: 1'b1, reg_addr: 5'd2, wr_data: 16'h0000, exp_rd: 16'h0141};
        vecs[1] = '{is_rd: 1'b0, reg_addr: 5'd4, wr_data: 16'h01E1, exp_rd: 16'h0000};
        vecs[2] = '{is_rd: 1'b1, reg_addr: 5'd4, wr_data: 16'h0000, exp_rd: 16'h01E1};
        vecs[3] = '{is_rd: 1'b1, reg_addr: 5'd3, wr_data: 16'h0000, exp_rd: 16'h0C54};
        vecs[4] = '{is_rd: 1'b0, reg_addr: 5'd3, wr_data: 16'hABCD, exp_rd: 16'h0000};
        vecs[5] = '{is_rd: 1'b1, reg_addr: 5'd3, wr_data: 16'h0000, exp_rd: 16'hABCD};

        // Reset, with a host read already requested so it must be held off
        rst_n         = 1'b0;
        host_req      = 1'b1;
        host_is_rd    = 1'b1;
        host_reg_addr = 5'd2;
        host_wr_data  = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({mdio_start, mdio_is_rd, mdio_reg_addr, mdio_wr_data, host_ack, init_done, link_up, link_chg, mdio_err}),
                    32'd0);
        checkOutput("reset_host_rd_data", 32'(host_rd_data), 32'd0);
        checkOutput("reset_phy_addr", 32'(mdio_phy_addr), 32'd1);
        rst_n = 1'b1;
        rel_cyc = cyc;

        // Init: one BMCR write, then reads until bit 15 clears
        waitInit(500, got);
        checkOutput("init_done_seen", 32'(got), 32'd1);
        checkOutput("init_write_count", 32'(init_writes), 32'd1);
        checkOutput("init_write_data", 32'(init_wdata), 32'h9140);
        checkOutput("init_write_delay", 32'(init_start_cyc - rel_cyc), 32'(RST_WAIT));
        checkOutput("init_read_count", 32'(init_reads), 32'd2);
        checkOutput("init_done_after_read", 32'(init_rise_cyc - last_init_vld_cyc), 32'd1);
        checkOutput("no_ack_during_init", 32'(ack_before_init), 32'd0);
        waitAck(100, got);
        host_req = 1'b0;
        checkOutput("held_host_ack_seen", 32'(got), 32'd1);
        checkOutput("held_host_rd_data", 32'(host_rd_data), 32'h0141);
        checkOutput("held_host_ack_latency", 32'(cyc - last_host_vld_cyc), 32'd1);

        // Poll: link comes up on the first BMSR read
        waitChg(1, 700, got);
        checkOutput("link_up_chg_seen", 32'(got), 32'd1);
        checkOutput("link_up_value", 32'(link_up), 32'd1);
        checkOutput("link_chg_latency", 32'(last_chg_cyc - last_poll_vld_cyc), 32'd1);
        @(negedge clk);
        checkOutput("link_chg_one_cycle", 32'(link_chg), 32'd0);

        // Poll: link goes down after BMSR changes
        bmsr = 16'h7969;
        waitChg(2, 700, got);
        checkOutput("link_down_chg_seen", 32'(got), 32'd1);
        checkOutput("link_down_value", 32'(link_up), 32'd0);
        checkOutput("poll_spacing_ge_interval",
                    32'((poll_q.size() >= 2) && (poll_q[1] - poll_q[0] >= POLL_INTERVAL)), 32'd1);

        // Table of host accesses
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Contention: host request held high back to back across several polls
        ord0 = order_q.size();
        bad_data = 0;
        host_is_rd    = 1'b1;
        host_reg_addr = 5'd2;
        host_wr_data  = 16'h0;
        host_req      = 1'b1;
        for (int k = 0; k < 30; k++) begin
            waitAck(500, got);
            if (!got) begin
                bad_data++;
                break;
            end
            if (host_rd_data != 16'h0141) bad_data++;
        end
        host_req = 1'b0;
        checkOutput("contention_host_results", 32'(bad_data), 32'd0);
        npoll = 0;
        viol = 0;
        for (int j = ord0; j < order_q.size(); j++) begin
            if (order_q[j]) begin
                npoll++;
                if (j + 1 < order_q.size() && order_q[j + 1]) viol++;
                if (j > ord0 && order_q[j - 1]) viol++;
            end
        end
        checkOutput("contention_polls_served", 32'(npoll >= 2), 32'd1);
        checkOutput("contention_alternation", 32'(viol), 32'd0);
        checkOutput("no_overlapping_start", 32'(overlap_errs), 32'd0);
        checkOutput("no_spurious_link_chg", 32'(chg_count), 32'd2);

        // Timeout: PHY never completes a host read
        suppress      = 1'b1;
        host_is_rd    = 1'b1;
        host_reg_addr = 5'd2;
        host_req      = 1'b1;
        waitAck(400, got);
        host_req = 1'b0;
        suppress = 1'b0;
        checkOutput("timeout_ack_seen", 32'(got), 32'd1);
        checkOutput("timeout_ack_cycle", 32'(cyc - last_host_start_cyc), 32'(TIMEOUT));
        checkOutput("timeout_rd_data", 32'(host_rd_data), 32'hFFFF);
        checkOutput("timeout_err_set", 32'(mdio_err), 32'd1);
        applyStimulus(vecs[0], 6);
        checkOutput("err_sticky", 32'(mdio_err), 32'd1);
        checkOutput("link_kept_after_timeout", 32'(link_up), 32'd0);

        // Reset in the middle of a poll restarts init
        p0 = poll_starts;
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (poll_starts > p0) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("poll_before_reset_seen", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_outputs",
                    32'({mdio_start, mdio_is_rd, mdio_reg_addr, mdio_wr_data, host_ack, init_done, link_up, link_chg, mdio_err}),
                    32'd0);
        checkOutput("midreset_host_rd_data", 32'(host_rd_data), 32'd0);
        w0 = init_writes;
        r0 = init_reads;
        rst_n = 1'b1;
        rel_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (init_writes > w0) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("reinit_write_seen", 32'(got), 32'd1);
        checkOutput("reinit_write_delay", 32'(init_start_cyc - rel_cyc), 32'(RST_WAIT));
        checkOutput("reinit_write_data", 32'(init_wdata), 32'h9140);
        waitInit(500, got);
        checkOutput("reinit_done_seen", 32'(got), 32'd1);
        checkOutput("reinit_read_count", 32'(init_reads - r0), 32'd2);
        checkOutput("final_no_overlap", 32'(overlap_errs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
